// File: rtl/shot_pool.sv
// Bullet pool for a duck-shooting game: spawns, moves, draws and expires player shots once per frame.
// Optional macro SHOT_COLLISION_EN compiles in duck collision, the hit pulse and the hit score.
`timescale 1ns/1ps
module shot_pool #(
    parameter int NUM_SHOTS = 8,
    parameter int SPEED     = 4,
    parameter int START_Y   = 440,
    parameter int SHOT_W    = 4,
    parameter int SHOT_H    = 8,
    parameter int COOLDOWN  = 8,
    parameter int DUCK_W    = 32,
    parameter int DUCK_H    = 32
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [9:0] gun_x,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic [9:0] duck_x,
    input  logic [9:0] duck_y,
    output logic       shot_draw,
    output logic [4:0] active_count,
    output logic       hit,
    output logic [7:0] hit_count
);

    logic                 sync1_q, sync2_q, fire_prev_q;
    logic                 pending_q, pending_d;
    logic [15:0]          cd_q, cd_d, cd_now;
    logic [9:0]           x_q [NUM_SHOTS];
    logic [9:0]           y_q [NUM_SHOTS];
    logic [9:0]           x_d [NUM_SHOTS];
    logic [9:0]           y_d [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] live_q, live_d;
    logic [NUM_SHOTS-1:0] coll;
    logic                 draw_q, draw_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 tick, fire_edge, has_free, taken;

    assign tick      = (hcount == 10'd0) && (vcount == 10'd480);
    assign fire_edge = sync2_q & ~fire_prev_q;
    assign has_free  = ~&live_q;
    // The decrement belongs to the current tick, so a shot fired COOLDOWN ticks after the last spawn is allowed.
    assign cd_now    = (cd_q != 16'd0) ? cd_q - 16'd1 : 16'd0;

`ifdef SHOT_COLLISION_EN
    always_comb begin
        for (int i = 0; i < NUM_SHOTS; i++) begin
            coll[i] = ({2'b0, x_q[i]} < {2'b0, duck_x} + 12'(DUCK_W)) &&
                      ({2'b0, duck_x} < {2'b0, x_q[i]} + 12'(SHOT_W)) &&
                      ({2'b0, y_q[i]} < {2'b0, duck_y} + 12'(DUCK_H)) &&
                      ({2'b0, duck_y} < {2'b0, y_q[i]} + 12'(SHOT_H));
        end
    end
`else
    assign coll = '0;
    logic unused_duck;
    assign unused_duck = ^{duck_x, duck_y};
`endif

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        live_d    = live_q;
        pending_d = pending_q;
        cd_d      = cd_q;
        cnt_d     = cnt_q;
        taken     = 1'b0;
        draw_d    = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (live_q[i] &&
                ({2'b0, hcount} >= {2'b0, x_q[i]}) && ({2'b0, hcount} < {2'b0, x_q[i]} + 12'(SHOT_W)) &&
                ({2'b0, vcount} >= {2'b0, y_q[i]}) && ({2'b0, vcount} < {2'b0, y_q[i]} + 12'(SHOT_H)))
                draw_d = 1'b1;
        end
        if (tick) begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (live_q[i]) begin
                    if (coll[i] || (y_q[i] < 10'(SPEED)))
                        live_d[i] = 1'b0;
                    else
                        y_d[i] = y_q[i] - 10'(SPEED);
                end
            end
            cd_d = cd_now;
            if (pending_q && (cd_now == 16'd0)) begin
                pending_d = 1'b0;
                if (has_free)
                    cd_d = 16'(COOLDOWN);
                // Only slots free before this tick are candidates, so a spawn never collides with a move.
                for (int i = 0; i < NUM_SHOTS; i++) begin
                    if (!live_q[i] && !taken) begin
                        taken     = 1'b1;
                        live_d[i] = 1'b1;
                        x_d[i]    = gun_x;
                        y_d[i]    = 10'(START_Y);
                    end
                end
            end
            cnt_d = '0;
            for (int i = 0; i < NUM_SHOTS; i++)
                cnt_d = cnt_d + {4'b0, live_d[i]};
        end
        if (fire_edge)
            pending_d = 1'b1;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            fire_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            cd_q        <= '0;
            live_q      <= '0;
            draw_q      <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            sync1_q     <= fire;
            sync2_q     <= sync1_q;
            fire_prev_q <= sync2_q;
            pending_q   <= pending_d;
            cd_q        <= cd_d;
            live_q      <= live_d;
            draw_q      <= draw_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign shot_draw    = draw_q;
    assign active_count = cnt_q;

`ifdef SHOT_COLLISION_EN
    logic       hit_q, hit_d, any_hit;
    logic [7:0] hc_q, hc_d;

    assign any_hit = tick && |(coll & live_q);

    always_comb begin
        hit_d = any_hit;
        hc_d  = hc_q;
        if (any_hit && (hc_q != 8'hFF))
            hc_d = hc_q + 8'd1;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hit_q <= 1'b0;
            hc_q  <= '0;
        end else begin
            hit_q <= hit_d;
            hc_q  <= hc_d;
        end
    end

    assign hit       = hit_q;
    assign hit_count = hc_q;
`else
    assign hit       = 1'b0;
    assign hit_count = '0;
`endif

endmodule

// File: doc/shot_pool.md
SHOT_POOL -- requirements
Module: shot_pool

Interface
REQ-001 The block SHALL have parameter NUM_SHOTS, 8, number of bullet slots (1..16).
REQ-002 The block SHALL have parameter SPEED, 4, pixels a bullet rises per frame.
REQ-003 The block SHALL have parameter START_Y, 440, spawn row of a new bullet.
REQ-004 The block SHALL have parameter SHOT_W / SHOT_H, 4 / 8, bullet box size in pixels.
REQ-005 The block SHALL have parameter COOLDOWN, 8, frames blocked after a spawn.
REQ-006 The block SHALL have parameter DUCK_W / DUCK_H, 32 / 32, duck hit-box size.
REQ-007 The block SHALL have port vga_clk, input, 1, pixel clock; the only clock.
REQ-008 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-009 The block SHALL have port fire, input, 1, raw asynchronous fire button level.
REQ-010 The block SHALL have port gun_x, input, 10, gun left-edge column.
REQ-011 The block SHALL have port hcount / vcount, input, 10 each, current raster position.
REQ-012 The block SHALL have port duck_x / duck_y, input, 10 each, duck top-left corner.
REQ-013 The block SHALL have port shot_draw, output, 1, current pixel belongs to a bullet.
REQ-014 The block SHALL have port active_count, output, 5, number of live slots.
REQ-015 The block SHALL have port hit, output, 1, one-cycle pulse on duck hit.
REQ-016 The block SHALL have port hit_count, output, 8, saturating hit score.

Function
REQ-017 fire SHALL pass a 2-FF synchroniser; a rising edge of the synchronised level SHALL set a pending flag.
REQ-018 Frame tick SHALL be the single cycle where hcount==0 and vcount==480; all slot updates occur only on it.
REQ-019 On tick, every live slot SHALL first be collision-checked, then moved y := y - SPEED.
REQ-020 A slot with y < SPEED at tick (before move) SHALL be freed instead of moved; no 10-bit underflow.
REQ-021 On tick with pending set and cooldown==0, the lowest-index free slot SHALL spawn at x = gun_x, y = START_Y; cooldown := COOLDOWN; pending cleared.
REQ-022 On tick with pending set and no free slot, the request SHALL be dropped (pending cleared, no cooldown load).
REQ-023 On tick with pending set and cooldown>0, pending SHALL remain set; cooldown decrements by 1 each tick until 0.
REQ-024 A slot spawned on a tick SHALL NOT be moved or collision-checked on that same tick.
REQ-025 Collision: slot box [x,x+SHOT_W)x[y,y+SHOT_H) overlapping duck box [duck_x,duck_x+DUCK_W)x[duck_y,duck_y+DUCK_H) SHALL free the slot.
REQ-026 Any collision on a tick SHALL pulse hit for exactly the cycle after the tick and increment hit_count by 1 (once per tick, even for multiple simultaneous hits), saturating at 255.
REQ-027 shot_draw SHALL be registered: asserted one cycle after (hcount,vcount) falls inside any live slot box.
REQ-028 active_count SHALL be registered, updated the cycle after each tick, equal to live slots.
REQ-029 A fire edge arriving on the tick cycle SHALL be served at the next tick.

Reset
REQ-030 While reset is high at a vga_clk edge: all slots free, pending=0, cooldown=0, sync FFs=0, shot_draw=0, active_count=0, hit=0, hit_count=0.
REQ-031 Reset asserted mid-frame SHALL discard all live bullets; no hit pulse SHALL be produced from the reset cycle.

Configuration
REQ-032 With macro SHOT_COLLISION_EN defined, REQ-025/REQ-026 collision logic SHALL be compiled in.
REQ-033 Without SHOT_COLLISION_EN, hit and hit_count SHALL be constant 0 and bullets SHALL only expire per REQ-020; all other behaviour unchanged.

Verification
REQ-034 Reset, one fire press, gun_x=300 -> after next tick slot0 at (300,440), active_count=1; shot_draw high one cycle after hcount=300,vcount=440.
REQ-035 Nine presses spaced 10 frames, no duck overlap -> 8 spawns then 9th dropped while all live; active_count never exceeds 8.
REQ-036 Two presses 2 frames apart -> second spawns exactly 8 ticks after the first (cooldown).
REQ-037 Bullet at y=3, SPEED=4 -> freed at tick, active_count decrements, no wrap to y~1023.
REQ-038 SHOT_COLLISION_EN defined, duck at (296,400), bullet from (300,440) -> hit pulse one cycle at the tick y reaches overlap, hit_count=1, slot freed; hit_count held at 255 after 256+ hits.
REQ-039 Reset pulsed with 5 live bullets -> next cycle active_count=0, shot_draw=0, hit_count=0.
